// File: rtl/iq_byte_splitter.sv
// Splits a little-endian interleaved I/Q byte stream into paired, sign-extended,
// left-shifted samples written in lockstep to the xreal and ximag FIFOs.
module iq_byte_splitter #(
    parameter int DATA_WIDTH = 32,
    parameter int QUANT_BITS = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            in_dout,
    input  logic                  in_empty,
    output logic                  in_rd_en,
    input  logic                  xreal_out_full,
    output logic                  xreal_out_wr_en,
    output logic [DATA_WIDTH-1:0] xreal_out_din,
    input  logic                  ximag_out_full,
    output logic                  ximag_out_wr_en,
    output logic [DATA_WIDTH-1:0] ximag_out_din
);

    typedef enum logic [2:0] {
        S_I_LO  = 3'd0,
        S_I_HI  = 3'd1,
        S_Q_LO  = 3'd2,
        S_Q_HI  = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    state_t      state_r;
    logic [15:0] i_word_r;
    logic [15:0] q_word_r;
    logic        byte_state_s;
    logic        pop_s;
    logic        go_s;

    function automatic logic [DATA_WIDTH-1:0] quantize(input logic [15:0] word);
        logic [DATA_WIDTH-1:0] ext;
        ext = {{(DATA_WIDTH-16){word[15]}}, word};
        return ext << QUANT_BITS;
    endfunction

    // Strobes are gated by reset so they drop to 0 immediately, not at the next edge.
    assign byte_state_s = (state_r == S_I_LO) || (state_r == S_I_HI) ||
                          (state_r == S_Q_LO) || (state_r == S_Q_HI);
    assign pop_s        = reset && byte_state_s && !in_empty;
    assign go_s         = reset && (state_r == S_WRITE) && !xreal_out_full && !ximag_out_full;

    assign in_rd_en        = pop_s;
    assign xreal_out_wr_en = go_s;
    assign ximag_out_wr_en = go_s;
    assign xreal_out_din   = quantize(i_word_r);
    assign ximag_out_din   = quantize(q_word_r);

    // Byte assembly and write-handshake state machine.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r  <= S_I_LO;
            i_word_r <= 16'd0;
            q_word_r <= 16'd0;
        end else begin
            case (state_r)
                S_I_LO: begin
                    if (pop_s) begin
                        i_word_r[7:0] <= in_dout;
                        state_r       <= S_I_HI;
                    end
                end
                S_I_HI: begin
                    if (pop_s) begin
                        i_word_r[15:8] <= in_dout;
                        state_r        <= S_Q_LO;
                    end
                end
                S_Q_LO: begin
                    if (pop_s) begin
                        q_word_r[7:0] <= in_dout;
                        state_r       <= S_Q_HI;
                    end
                end
                S_Q_HI: begin
                    if (pop_s) begin
                        q_word_r[15:8] <= in_dout;
                        state_r        <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (go_s) begin
                        state_r <= S_I_LO;
                    end
                end
                default: begin
                    state_r <= S_I_LO;
                end
            endcase
        end
    end

endmodule
